// File: rtl/wallace_arbiter_if.sv
// rtl/wallace_arbiter_if.sv - requester, response and multiplier signals of the shared Wallace multiplier arbiter
interface wallace_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_A;
  logic [3:0] req0_B;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_A;
  logic [3:0] req1_B;
  logic       req1_ready;
  logic [3:0] mul_A;
  logic [3:0] mul_B;
  logic [7:0] mul_P;
  logic       rsp0_valid;
  logic [7:0] rsp0_P;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic [7:0] rsp1_P;
  logic       rsp1_ready;
  logic       busy;
  logic       grant_id;

  modport slave (
    input  req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
    input  mul_P, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, mul_A, mul_B,
    output rsp0_valid, rsp0_P, rsp1_valid, rsp1_P, busy, grant_id
  );

  modport master (
    output req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
    output mul_P, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, mul_A, mul_B,
    input  rsp0_valid, rsp0_P, rsp1_valid, rsp1_P, busy, grant_id
  );
endinterface

// File: rtl/wallace_arbiter.sv
// rtl/wallace_arbiter.sv - two-requester arbiter in front of one combinational 4x4 Wallace multiplier
// Optional WALLACE_ARB_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module wallace_arbiter #(
  parameter int MUL_LAT = 1
) (
  input logic              in_Clk,
  input logic              reset,
  wallace_arbiter_if.slave bus
);

  // Settle time is clamped to the 4-bit counter range; 0 behaves as 1.
  localparam int         LAT_I = (MUL_LAT < 1) ? 1 : ((MUL_LAT > 15) ? 15 : MUL_LAT);
  localparam logic [3:0] LAT   = LAT_I[3:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t     r_state;
  logic [3:0] r_mul_a;
  logic [3:0] r_mul_b;
  logic [7:0] r_rsp0_p;
  logic [7:0] r_rsp1_p;
  logic       r_rsp0_valid;
  logic       r_rsp1_valid;
  logic       r_grant_id;
  logic       r_last_grant;
  logic [3:0] r_cnt;

  logic w_win_id;
  logic w_ready0;
  logic w_ready1;
  logic w_rsp_take;

  always_comb begin
    w_win_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef WALLACE_ARB_FIXED_PRIO_EN
      w_win_id = 1'b0;
`else
      w_win_id = ~r_last_grant;
`endif
    end else begin
      w_win_id = bus.req1_valid;
    end
  end

  assign w_ready0   = reset && (r_state == ST_IDLE) && bus.req0_valid && !w_win_id;
  assign w_ready1   = reset && (r_state == ST_IDLE) && bus.req1_valid && w_win_id;
  // Only the owning channel's ready can complete the response.
  assign w_rsp_take = r_grant_id ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge in_Clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_mul_a      <= 4'd0;
      r_mul_b      <= 4'd0;
      r_rsp0_p     <= 8'd0;
      r_rsp1_p     <= 8'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ready0 || w_ready1) begin
            r_mul_a      <= w_ready1 ? bus.req1_A : bus.req0_A;
            r_mul_b      <= w_ready1 ? bus.req1_B : bus.req0_B;
            r_grant_id   <= w_ready1;
            r_last_grant <= w_ready1;
            r_cnt        <= LAT;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            if (r_grant_id) begin
              r_rsp1_p     <= bus.mul_P;
              r_rsp1_valid <= 1'b1;
            end else begin
              r_rsp0_p     <= bus.mul_P;
              r_rsp0_valid <= 1'b1;
            end
            r_cnt   <= 4'd0;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (w_rsp_take) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.mul_A      = r_mul_a;
  assign bus.mul_B      = r_mul_b;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_P     = r_rsp0_p;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_P     = r_rsp1_p;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.grant_id   = r_grant_id;

endmodule

// File: tb/tb_wallace_arbiter.sv
// tb/tb_wallace_arbiter.sv - directed self-checking bench for wallace_arbiter (MUL_LAT 1 and 4 instances)
module tb_wallace_arbiter;

  logic in_Clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  wallace_arbiter_if bus1 ();
  wallace_arbiter_if bus4 ();

  assign bus1.mul_P = {4'd0, bus1.mul_A} * {4'd0, bus1.mul_B};
  assign bus4.mul_P = {4'd0, bus4.mul_A} * {4'd0, bus4.mul_B};

  wallace_arbiter #(.MUL_LAT(1)) u_dut1 (.in_Clk(in_Clk), .reset(reset), .bus(bus1.slave));
  wallace_arbiter #(.MUL_LAT(4)) u_dut4 (.in_Clk(in_Clk), .reset(reset), .bus(bus4.slave));

  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_Clk);
    @(negedge in_Clk);
  endtask

  initial begin
    int busy_cnt;
    int first_valid;
    int exp_id;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus1.req0_valid = 0; bus1.req0_A = 0; bus1.req0_B = 0;
    bus1.req1_valid = 0; bus1.req1_A = 0; bus1.req1_B = 0;
    bus1.rsp0_ready = 0; bus1.rsp1_ready = 0;
    bus4.req0_valid = 0; bus4.req0_A = 0; bus4.req0_B = 0;
    bus4.req1_valid = 0; bus4.req1_A = 0; bus4.req1_B = 0;
    bus4.rsp0_ready = 0; bus4.rsp1_ready = 0;
    @(negedge in_Clk);
    tick();
    tick();

    // Reset state, including ready forced low while reset is held
    bus1.req0_valid = 1;
    #1;
    chk("rst_busy", bus1.busy, 0);
    chk("rst_mulA", bus1.mul_A, 0);
    chk("rst_grant", bus1.grant_id, 0);
    chk("rst_rsp0v", bus1.rsp0_valid, 0);
    chk("rst_rsp1P", bus1.rsp1_P, 0);
    chk("rst_ready0", bus1.req0_ready, 0);
    bus1.req0_valid = 0;
    @(negedge in_Clk);
    reset = 1'b1;
    tick();

    // req0 alone, 3x5, MUL_LAT=1
    bus1.req0_valid = 1; bus1.req0_A = 3; bus1.req0_B = 5; bus1.rsp0_ready = 1;
    #1;
    chk("t1_ready0", bus1.req0_ready, 1);
    chk("t1_ready1", bus1.req1_ready, 0);
    tick();
    bus1.req0_valid = 0;
    chk("t1_busy", bus1.busy, 1);
    chk("t1_mulA", bus1.mul_A, 3);
    chk("t1_mulB", bus1.mul_B, 5);
    chk("t1_rsp0v_early", bus1.rsp0_valid, 0);
    tick();
    chk("t1_rsp0v", bus1.rsp0_valid, 1);
    chk("t1_rsp0P", bus1.rsp0_P, 15);
    chk("t1_rsp1v", bus1.rsp1_valid, 0);
    tick();
    chk("t1_rsp0v_done", bus1.rsp0_valid, 0);
    chk("t1_idle", bus1.busy, 0);

    // req1 alone, 15x15, MUL_LAT=4
    bus4.req1_valid = 1; bus4.req1_A = 15; bus4.req1_B = 15; bus4.rsp1_ready = 1;
    #1;
    chk("t2_ready1", bus4.req1_ready, 1);
    busy_cnt = 0;
    first_valid = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus4.req1_valid = 0;
      if (bus4.busy) busy_cnt++;
      if (bus4.rsp1_valid && first_valid < 0) begin
        first_valid = i;
        chk("t2_rsp1P", bus4.rsp1_P, 225);
        chk("t2_grant", bus4.grant_id, 1);
      end
      chk("t2_rsp0v", bus4.rsp0_valid, 0);
    end
    chk("t2_busy_cycles", busy_cnt, 5);
    chk("t2_latency", first_valid, 4);

    // Backpressure on rsp0 while req1 waits
    bus1.req0_valid = 1; bus1.req0_A = 3; bus1.req0_B = 5; bus1.rsp0_ready = 0;
    #1;
    chk("t4_ready0", bus1.req0_ready, 1);
    tick();
    bus1.req0_valid = 0;
    bus1.req1_valid = 1; bus1.req1_A = 2; bus1.req1_B = 3; bus1.rsp1_ready = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold_v", bus1.rsp0_valid, 1);
      chk("t4_hold_P", bus1.rsp0_P, 15);
      chk("t4_hold_ready1", bus1.req1_ready, 0);
      tick();
    end
    bus1.rsp0_ready = 1;
    tick();
    #1;
    chk("t4_rel_v", bus1.rsp0_valid, 0);
    chk("t4_rel_busy", bus1.busy, 0);
    chk("t4_rel_ready1", bus1.req1_ready, 1);
    tick();
    bus1.req1_valid = 0;
    chk("t4_grant1", bus1.grant_id, 1);
    chk("t4_mulA", bus1.mul_A, 2);
    tick();
    chk("t4_rsp1v", bus1.rsp1_valid, 1);
    chk("t4_rsp1P", bus1.rsp1_P, 6);
    tick();

    // Operands change while req0 is stalled; only accept-time values count
    bus1.req1_valid = 1; bus1.req1_A = 1; bus1.req1_B = 2;
    tick();
    bus1.req1_valid = 0;
    bus1.req0_valid = 1; bus1.req0_A = 1; bus1.req0_B = 1;
    #1;
    chk("t6_stall_wait", bus1.req0_ready, 0);
    tick();
    bus1.req0_A = 4; bus1.req0_B = 4;
    #1;
    chk("t6_stall_resp", bus1.req0_ready, 0);
    tick();
    #1;
    chk("t6_ready0", bus1.req0_ready, 1);
    tick();
    bus1.req0_valid = 0;
    chk("t6_mulA", bus1.mul_A, 4);
    tick();
    chk("t6_rsp0P", bus1.rsp0_P, 16);
    tick();

    // Reset during WAIT discards the operation
    bus1.req1_valid = 1; bus1.req1_A = 3; bus1.req1_B = 3;
    tick();
    bus1.req1_valid = 0;
    chk("t5_inflight", bus1.busy, 1);
    reset = 1'b0;
    tick();
    chk("t5_busy", bus1.busy, 0);
    chk("t5_mulA", bus1.mul_A, 0);
    chk("t5_grant", bus1.grant_id, 0);
    chk("t5_rsp1v", bus1.rsp1_valid, 0);
    chk("t5_rsp0P", bus1.rsp0_P, 0);
    reset = 1'b1;
    tick();
    chk("t5_no_rsp", bus1.rsp1_valid, 0);

    // Both valid continuously: round-robin starting at req0
    bus1.req0_valid = 1; bus1.req0_A = 2; bus1.req0_B = 7;
    bus1.req1_valid = 1; bus1.req1_A = 6; bus1.req1_B = 9;
    bus1.rsp0_ready = 1; bus1.rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef WALLACE_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % 2;
`endif
      #1;
      chk("t3_ready0", bus1.req0_ready, (exp_id == 0) ? 1 : 0);
      chk("t3_ready1", bus1.req1_ready, (exp_id == 1) ? 1 : 0);
      tick();
      chk("t3_grant", bus1.grant_id, exp_id);
      tick();
      if (exp_id == 0) begin
        chk("t3_rsp0v", bus1.rsp0_valid, 1);
        chk("t3_rsp0P", bus1.rsp0_P, 14);
        chk("t3_rsp1v_off", bus1.rsp1_valid, 0);
      end else begin
        chk("t3_rsp1v", bus1.rsp1_valid, 1);
        chk("t3_rsp1P", bus1.rsp1_P, 54);
        chk("t3_rsp0v_off", bus1.rsp0_valid, 0);
      end
      tick();
    end
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
